// File: rtl/thread_lsu.sv
// Per-thread load/store unit: one memory read or write per LDR/STR, stepped by core_state.
// Optional WAITING watchdog enabled by defining LSU_TIMEOUT_EN.
module thread_lsu #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [2:0] CS_WAIT   = 3'b100;
  localparam logic [2:0] CS_UPDATE = 3'b110;

  state_t               state, state_n;
  logic                 op_read, op_read_n;
  logic                 rd_vld_n, wr_vld_n;
  logic [ADDR_BITS-1:0] rd_addr_n, wr_addr_n;
  logic [DATA_BITS-1:0] wr_data_n, out_n;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_n;
  logic       err_n;
`endif

  assign lsu_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      op_read           <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt          <= '0;
      lsu_error         <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      op_read           <= op_read_n;
      mem_read_valid    <= rd_vld_n;
      mem_read_address  <= rd_addr_n;
      mem_write_valid   <= wr_vld_n;
      mem_write_address <= wr_addr_n;
      mem_write_data    <= wr_data_n;
      lsu_out           <= out_n;
`ifdef LSU_TIMEOUT_EN
      wait_cnt          <= wait_cnt_n;
      lsu_error         <= err_n;
`endif
    end
  end

`ifndef LSU_TIMEOUT_EN
  assign lsu_error = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    op_read_n = op_read;
    rd_vld_n  = mem_read_valid;
    rd_addr_n = mem_read_address;
    wr_vld_n  = mem_write_valid;
    wr_addr_n = mem_write_address;
    wr_data_n = mem_write_data;
    out_n     = lsu_out;
`ifdef LSU_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
    err_n      = lsu_error;
`endif
    case (state)
      S_IDLE: begin
        // read wins when both enables are set
        if (enable && core_state == CS_WAIT &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_n   = S_REQ;
          op_read_n = decoded_mem_read_enable;
        end
      end
      S_REQ: begin
        if (op_read) begin
          rd_vld_n  = 1'b1;
          rd_addr_n = ADDR_BITS'(rs);
        end else begin
          wr_vld_n  = 1'b1;
          wr_addr_n = ADDR_BITS'(rs);
          wr_data_n = rt;
        end
`ifdef LSU_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (op_read && mem_read_ready) begin
          out_n    = mem_read_data;
          rd_vld_n = 1'b0;
          state_n  = S_DONE;
        end else if (!op_read && mem_write_ready) begin
          wr_vld_n = 1'b0;
          state_n  = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          rd_vld_n = 1'b0;
          wr_vld_n = 1'b0;
          err_n    = 1'b1;
          state_n  = S_DONE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
`endif
      end
      S_DONE: begin
        rd_vld_n = 1'b0;
        wr_vld_n = 1'b0;
        if (core_state == CS_UPDATE) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_thread_lsu.sv
// Scoreboard bench for thread_lsu: expected requests queued at trigger, popped when valid appears.
module tb_thread_lsu;
  logic       clk = 1'b0;
  logic       reset, enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  always #5 clk = ~clk;

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  typedef struct {bit is_read; logic [7:0] addr; logic [7:0] data;} exp_t;
  exp_t       sbq[$];
  exp_t       cur;
  logic [7:0] model_out;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    enable = 0; core_state = 3'b000; rd_en = 0; wr_en = 0;
    mem_read_ready = 0; mem_write_ready = 0;
  endtask

  task automatic check_valid_held(input string tag);
    chk({tag, "_state"}, lsu_state, 2'b10);
    chk({tag, "_rvld"}, mem_read_valid, cur.is_read);
    chk({tag, "_wvld"}, mem_write_valid, !cur.is_read);
    if (cur.is_read) chk({tag, "_raddr"}, mem_read_address, cur.addr);
    else begin
      chk({tag, "_waddr"}, mem_write_address, cur.addr);
      chk({tag, "_wdata"}, mem_write_data, cur.data);
    end
  endtask

  // Trigger an instruction and wait (bounded) for the request to appear.
  task automatic trigger(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int n;
    e.is_read = rd; e.addr = a; e.data = d;
    sbq.push_back(e);
    enable = 1; core_state = 3'b100; rd_en = rd; wr_en = wr; rs = a; rt = d;
    step();
    chk("req_state", lsu_state, 2'b01);
    n = 1;
    while (!(mem_read_valid || mem_write_valid) && n < 10) begin
      step(); n++;
    end
    chk("valid_latency", n, 2);
    cur = sbq.pop_front();
    rs = ~a; rt = ~d;  // operands may change once latched
    check_valid_held("req");
  endtask

  task automatic complete(input logic [7:0] rdata, input int stall);
    for (int i = 0; i < stall; i++) begin
      step();
      check_valid_held("stall");
    end
    if (cur.is_read) begin mem_read_ready = 1; mem_read_data = rdata; model_out = rdata; end
    else mem_write_ready = 1;
    step();
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 8'hEE;
    chk("done_state", lsu_state, 2'b11);
    chk("done_rvld", mem_read_valid, 1'b0);
    chk("done_wvld", mem_write_valid, 1'b0);
    chk("done_out", lsu_out, model_out);
    mem_read_ready = 1; mem_read_data = 8'h99;  // ready in DONE is ignored
    step();
    mem_read_ready = 0;
    chk("done_hold", lsu_state, 2'b11);
    chk("done_hold_out", lsu_out, model_out);
    core_state = 3'b110;
    step();
    chk("update_idle", lsu_state, 2'b00);
    idle_inputs();
  endtask

  initial begin
    reset = 1; idle_inputs(); rs = 0; rt = 0; mem_read_data = 0; model_out = 0;
    step(); step();
    chk("rst_state", lsu_state, 2'b00);
    chk("rst_rvld", mem_read_valid, 1'b0);
    chk("rst_wvld", mem_write_valid, 1'b0);
    chk("rst_out", lsu_out, 8'h00);
    chk("rst_err", lsu_error, 1'b0);
    reset = 0;
    step();

    // load with 3-cycle stall
    trigger(1, 0, 8'h2A, 8'h00);
    complete(8'h5C, 3);

    // store with 4-cycle stall; lsu_out keeps 0x5C
    trigger(0, 1, 8'h10, 8'hA5);
    complete(8'h00, 4);

    // no trigger: wrong core_state, then enable low
    enable = 1; rd_en = 1; core_state = 3'b011;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("notrig_cs_vld", {mem_read_valid, mem_write_valid}, 2'b00);
      chk("notrig_cs_state", lsu_state, 2'b00);
    end
    enable = 0; core_state = 3'b100; wr_en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("notrig_en_vld", {mem_read_valid, mem_write_valid}, 2'b00);
      chk("notrig_en_state", lsu_state, 2'b00);
    end
    idle_inputs();

    // reset while WAITING
    trigger(1, 0, 8'h77, 8'h00);
    step();
    reset = 1;
    step();
    model_out = 8'h00;
    chk("rstw_rvld", mem_read_valid, 1'b0);
    chk("rstw_state", lsu_state, 2'b00);
    chk("rstw_out", lsu_out, 8'h00);
    idle_inputs();
    reset = 0;
    step();
    trigger(1, 0, 8'h81, 8'h00);
    complete(8'h3E, 1);

    // both enables: read wins
    trigger(1, 1, 8'h33, 8'h66);
    complete(8'hC7, 2);

`ifdef LSU_TIMEOUT_EN
    trigger(1, 0, 8'h44, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step();
      check_valid_held("to_wait");
      chk("to_err_low", lsu_error, 1'b0);
    end
    step();
    chk("to_state", lsu_state, 2'b11);
    chk("to_rvld", mem_read_valid, 1'b0);
    chk("to_err", lsu_error, 1'b1);
    chk("to_out", lsu_out, model_out);
    core_state = 3'b110;
    step();
    chk("to_idle", lsu_state, 2'b00);
    chk("to_err_sticky", lsu_error, 1'b1);
    idle_inputs();
    step();
    chk("to_err_sticky2", lsu_error, 1'b1);
    reset = 1;
    step();
    reset = 0;
    chk("to_err_clr", lsu_error, 1'b0);
`else
    // without the watchdog a long stall just keeps waiting
    trigger(0, 1, 8'h5A, 8'h0F);
    for (int i = 0; i < 70; i++) step();
    check_valid_held("long_wait");
    chk("long_err", lsu_error, 1'b0);
    complete(8'h00, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
